// File: rtl/cmp_word_accumulator.sv
// Word-level magnitude comparator: folds MSB-first one-hot digit verdicts into one
// verdict per NUM_DIGITS-digit word, with valid/ready on both sides and a sticky error flag.
module cmp_word_accumulator #(
    parameter int NUM_DIGITS = 4,
    parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_result,
    input  logic       in_first,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_result,
    output logic       err
);

    localparam logic [2:0] GT = 3'b001;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_decided;
    logic [2:0]       r_verdict;
    logic             r_out_valid;
    logic [2:0]       r_out_result;
    logic             r_err;

    logic             w_acc;
    logic             w_onehot;
    logic [2:0]       w_digit;
    logic             w_restart;
    logic             w_err_evt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_next_decided;
    logic [2:0]       w_next_verdict;

    assign in_ready   = (r_state != DONE) & ~rst;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign err        = r_err;

    assign w_acc    = in_valid & in_ready;
    assign w_onehot = (in_result == GT) | (in_result == EQ) | (in_result == LT);
    // Malformed digit codes carry no ordering information, so they behave as "equal".
    assign w_digit  = w_onehot ? in_result : EQ;

    // A digit starts a new word in IDLE regardless of in_first, or in ACC when in_first
    // interrupts the word in progress.
    assign w_restart = (r_state == IDLE) | in_first;
    assign w_err_evt = ~w_onehot
                     | ((r_state == IDLE) & ~in_first)
                     | ((r_state == ACC) & in_first);

    always_comb begin
        w_next_cnt     = r_cnt + CNT_W'(1);
        w_next_decided = r_decided;
        w_next_verdict = r_verdict;
        if (w_restart) begin
            w_next_cnt     = CNT_W'(1);
            w_next_decided = (w_digit != EQ);
            w_next_verdict = w_digit;
        end else if (!r_decided && (w_digit != EQ)) begin
            w_next_decided = 1'b1;
            w_next_verdict = w_digit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_decided    <= 1'b0;
            r_verdict    <= EQ;
            r_out_valid  <= 1'b0;
            r_out_result <= 3'b000;
            r_err        <= 1'b0;
        end else if (w_acc) begin
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
            r_cnt     <= w_next_cnt;
            r_decided <= w_next_decided;
            r_verdict <= w_next_verdict;
            if (w_next_cnt == CNT_W'(NUM_DIGITS)) begin
                r_state      <= DONE;
                r_out_valid  <= 1'b1;
                r_out_result <= w_next_verdict;
            end else begin
                r_state <= ACC;
            end
        end else if ((r_state == DONE) && out_ready) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmp_word_accumulator.sv
// Directed bench for cmp_word_accumulator with NUM_DIGITS=4.
module tb_cmp_word_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_result;
    logic       in_first;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_result;
    logic       err;

    int total = 0;
    int bad   = 0;

    cmp_word_accumulator #(.NUM_DIGITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_first   (in_first),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] res, input logic first);
        in_valid  = 1'b1;
        in_result = res;
        in_first  = first;
        tick();
        in_valid  = 1'b0;
        in_first  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out_result !== 3'b000) begin bad++; $display("FAIL rst_out_result got=%b exp=000", out_result); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready_during got=%b exp=0", in_ready); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready_after got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        send(3'b010, 1'b1);
        send(3'b010, 1'b0);
        send(3'b001, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
        send(3'b100, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        total++; if (out_result !== 3'b001) begin bad++; $display("FAIL basic_result got=%b exp=001", out_result); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", err); end
        consume();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_equal_and_msb();
        for (int i = 0; i < 4; i++) send(3'b010, i == 0);
        total++; if (out_result !== 3'b010 || out_valid !== 1'b1) begin bad++; $display("FAIL all_equal got=%b/%b exp=1/010", out_valid, out_result); end
        consume();
        send(3'b100, 1'b1);
        tick();
        send(3'b001, 1'b0);
        tick();
        tick();
        send(3'b001, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL gap_early_valid got=%b exp=0", out_valid); end
        send(3'b001, 1'b0);
        total++; if (out_result !== 3'b100 || out_valid !== 1'b1) begin bad++; $display("FAIL msb_wins got=%b/%b exp=1/100", out_valid, out_result); end
        consume();
    endtask

    task automatic test_backpressure();
        send(3'b001, 1'b1);
        send(3'b100, 1'b0);
        send(3'b010, 1'b0);
        send(3'b010, 1'b0);
        in_valid  = 1'b1;
        in_first  = 1'b1;
        in_result = 3'b100;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_result !== 3'b001 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_%0d got=%b/%b/%b exp=1/001/0", i, out_valid, out_result, in_ready);
            end
            tick();
        end
        in_valid  = 1'b0;
        in_first  = 1'b0;
        consume();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL release got=%b/%b exp=1/0", in_ready, out_valid); end
        for (int i = 0; i < 3; i++) send(3'b010, i == 0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL no_stray_digit got=%b exp=0", out_valid); end
        send(3'b010, 1'b0);
        total++; if (out_result !== 3'b010) begin bad++; $display("FAIL after_hold_result got=%b exp=010", out_result); end
        consume();
    endtask

    task automatic test_restart();
        do_reset();
        send(3'b001, 1'b1);
        send(3'b010, 1'b0);
        send(3'b100, 1'b1);
        send(3'b010, 1'b0);
        send(3'b010, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL restart_aborted_word got=%b exp=0", out_valid); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL restart_err got=%b exp=1", err); end
        send(3'b010, 1'b0);
        total++; if (out_valid !== 1'b1 || out_result !== 3'b100) begin bad++; $display("FAIL restart_result got=%b/%b exp=1/100", out_valid, out_result); end
        consume();
    endtask

    task automatic test_no_first();
        do_reset();
        for (int i = 0; i < 4; i++) send(i == 1 ? 3'b100 : 3'b010, 1'b0);
        total++; if (out_valid !== 1'b1 || out_result !== 3'b100) begin bad++; $display("FAIL no_first_result got=%b/%b exp=1/100", out_valid, out_result); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL no_first_err got=%b exp=1", err); end
        consume();
    endtask

    task automatic test_bad_code();
        do_reset();
        send(3'b010, 1'b1);
        send(3'b011, 1'b0);
        send(3'b001, 1'b0);
        send(3'b010, 1'b0);
        total++; if (out_valid !== 1'b1 || out_result !== 3'b001) begin bad++; $display("FAIL bad_code_result got=%b/%b exp=1/001", out_valid, out_result); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL bad_code_err got=%b exp=1", err); end
        consume();
        send(3'b100, 1'b1);
        for (int i = 0; i < 3; i++) send(3'b010, 1'b0);
        total++; if (out_result !== 3'b100 || err !== 1'b1) begin bad++; $display("FAIL sticky_err got=%b/%b exp=100/1", out_result, err); end
        consume();
    endtask

    task automatic test_rst_abort();
        send(3'b001, 1'b1);
        send(3'b010, 1'b0);
        rst = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || out_result !== 3'b000 || err !== 1'b0) begin bad++; $display("FAIL rst_midword got=%b/%b/%b exp=0/000/0", out_valid, out_result, err); end
        rst = 1'b0;
        send(3'b001, 1'b1);
        send(3'b010, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_midword_cnt got=%b exp=0", out_valid); end
        send(3'b010, 1'b0);
        send(3'b010, 1'b0);
        total++; if (out_valid !== 1'b1 || out_result !== 3'b001) begin bad++; $display("FAIL pre_rst_done got=%b/%b exp=1/001", out_valid, out_result); end
        rst = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || out_result !== 3'b000) begin bad++; $display("FAIL rst_done got=%b/%b exp=0/000", out_valid, out_result); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_done_ready got=%b exp=1", in_ready); end
        send(3'b100, 1'b1);
        for (int i = 0; i < 3; i++) send(3'b010, 1'b0);
        total++; if (out_valid !== 1'b1 || out_result !== 3'b100 || err !== 1'b0) begin bad++; $display("FAIL fresh_word got=%b/%b/%b exp=1/100/0", out_valid, out_result, err); end
        consume();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 4; i++) send((w == 0 && i == 2) ? 3'b100 : ((w == 1 && i == 0) ? 3'b001 : 3'b010), i == 0);
            total++;
            if (out_valid !== 1'b1 || out_result !== (w == 0 ? 3'b100 : 3'b001) || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL b2b_word%0d got=%b/%b/%b", w, out_valid, out_result, in_ready);
            end
            tick();
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_xfer%0d got=%b/%b exp=0/1", w, out_valid, in_ready); end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_result = 3'b010;
        in_first  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_equal_and_msb();
        test_backpressure();
        test_restart();
        test_no_first();
        test_bad_code();
        test_rst_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
